cal_pulse_gen: RTL and testbench
================================

# cal_pulse_gen

Programmable periodic pulse source for the measure unit. It is the transmit-side counterpart of the strobe generator's period detector. It emits single- or multi-cycle pulses with a clocked period, either continuously or as a fixed-length burst. The calibration controller uses it to stimulate the comparator path, and the strobe generator then measures and reproduces that period.

## Interface
- CNT_WIDTH, 32, width of the period and width configuration counters
- BURST_WIDTH, 16, width of the burst length and pulse counter

- clk_i  in  1  system clock; all logic is on the rising edge
- arst_i  in  1  asynchronous reset, active-high; clears all state and outputs immediately
- period_i  in  CNT_WIDTH  pulse period in clk_i cycles; sampled on an accepted start
- width_i  in  CNT_WIDTH  high time in clk_i cycles; sampled on an accepted start
- burst_i  in  BURST_WIDTH  number of pulses to emit; 0 means continuous
- start_i  in  1  level-sampled start request; accepted only in IDLE
- stop_i  in  1  abort request; has priority over start_i
- oe_i  in  1  output enable; gates pulse_o only, internal counting continues
- pulse_o  out  1  generated pulse, equal to pulse_q & oe_i
- busy_o  out  1  high while in HIGH or LOW state
- done_o  out  1  one-cycle flag when a burst completes or a stop is taken
- err_o  out  1  sticky configuration error; cleared by the next accepted valid start
- pulse_cnt_o  out  BURST_WIDTH  count of rising edges of pulse_q since the last accepted start

## Operation
- States: IDLE, HIGH, LOW. Reset state is IDLE.
- Reset values: pulse_q=0, busy_o=0, done_o=0, err_o=0, pulse_cnt_o=0, phase=0, all latched config=0.
- IDLE and start_i=1 and stop_i=0 (one edge):
  - Config is valid iff period_i≥2 and 1≤width_i≤period_i−1.
  - Valid config: latch period, width and burst; phase←0; pulse_cnt_o←1; err_o←0; pulse_q←1; go to HIGH.
  - Invalid config: err_o←1; stay in IDLE; pulse_q stays 0; pulse_cnt_o is unchanged.
- Phase counter: runs 0..P−1 and wraps to 0. pulse_q=1 while phase<W.
  - HIGH→LOW when phase reaches W−1.
  - LOW→HIGH when phase reaches P−1, unless the burst is complete.
  - On each LOW→HIGH transition, pulse_cnt_o increments. In continuous mode it wraps modulo 2^BURST_WIDTH.
- Burst complete: burst≠0, phase=P−1 and pulse_cnt_o=burst. The FSM goes to IDLE, done_o pulses for one cycle, and busy_o drops on the same edge.
- stop_i=1 in HIGH or LOW: on the next edge pulse_q←0, state←IDLE, done_o←1 for one cycle. pulse_cnt_o holds its value.
- stop_i in IDLE: no effect; done_o is not asserted.
- start_i while busy: ignored, no error. Latched config is unaffected by input changes while running.
- Arithmetic: phase compare is unsigned at CNT_WIDTH. The period must not exceed 2^CNT_WIDTH−1; the validity check guarantees no overflow.

## Timing
- Start accepted at edge N: pulse_q rises at edge N (registered), so it is visible from cycle N+1. busy_o rises at the same edge.
- Rising edges of pulse_q occur at N, N+P, N+2P, … Each high time is exactly W cycles.
- Burst of B pulses: done_o is high for the single cycle following edge N+B·P. A new start can be accepted at that edge+1 or later.
- Stop sampled at edge S: pulse_q=0 and done_o=1 after edge S; done_o clears after edge S+1.
- err_o asserts after the sampling edge and holds until a valid start is accepted.
- pulse_o follows oe_i combinationally with zero latency. busy_o, done_o and pulse_cnt_o ignore oe_i.
- arst_i asserted mid-pulse: pulse_o drops asynchronously. After release, the block restarts only on a new start_i.

## Test plan
- Continuous, clk 8 ns, P=20, W=1, B=0: pulse_o rising edges spaced exactly 160 ns over 12 periods; busy_o stays 1; done_o never asserts.
- Burst, P=5, W=2, B=3, start at edge N: pulse_q high on cycles N..N+1, N+5..N+6, N+10..N+11; done_o single cycle after edge N+15; pulse_cnt_o=3; busy_o=0.
- Invalid config: P=1 → err_o=1, pulse_o stays 0, busy_o=0. Then P=4, W=4 → err_o still 1. Then P=4, W=3 → err_o clears and pulses run.
- Stop during HIGH with P=10, W=6, stop at phase 2: pulse_o=0 next cycle, done_o=1 for one cycle, pulse_cnt_o holds. Simultaneous start+stop in IDLE: nothing happens.
- oe_i=0 during a B=4, P=8 burst: pulse_o stays 0, but done_o still fires at N+32 and pulse_cnt_o=4.
- arst_i pulsed mid-burst: all outputs go to 0 immediately. Re-start with P=6, W=3 produces a first rising edge on the accepting edge.

Source files
------------

// File: rtl/cal_pulse_gen.sv
// rtl/cal_pulse_gen.sv - programmable periodic pulse source (continuous or burst)
//
// Purpose:
//   Emits pulses of width_i cycles every period_i cycles, either forever
//   (burst_i == 0) or for exactly burst_i pulses. Configuration is sampled
//   on an accepted start and held for the whole run.
//
// Ports:
//   clk_i        system clock, rising edge
//   arst_i       asynchronous active-high reset
//   period_i     pulse period in clk_i cycles (sampled on accepted start)
//   width_i      pulse high time in clk_i cycles (sampled on accepted start)
//   burst_i      number of pulses, 0 = continuous (sampled on accepted start)
//   start_i      level start request, accepted only when idle
//   stop_i       abort request, wins over start_i
//   oe_i         output enable, gates pulse_o only
//   pulse_o      generated pulse (pulse_q & oe_i)
//   busy_o       high while a run is in progress
//   done_o       one-cycle flag on burst completion or taken stop
//   err_o        sticky configuration error, cleared by next valid start
//   pulse_cnt_o  rising edges of the pulse since the last accepted start

module cal_pulse_gen #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [CNT_WIDTH-1:0]   period_i,
  input  logic [CNT_WIDTH-1:0]   width_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   oe_i,
  output logic                   pulse_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [BURST_WIDTH-1:0] pulse_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   C_TWO = {{(CNT_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [BURST_WIDTH-1:0] B_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   width_q, width_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Decode of the current run position and the start request.
  logic start_req;
  logic cfg_valid;
  logic at_high_end;
  logic at_period_end;
  logic burst_complete;
  logic running;

  // width_i < period_i implies width_i <= period_i - 1 without an underflow risk.
  assign cfg_valid      = (period_i >= C_TWO) && (width_i != '0) && (width_i < period_i);
  assign start_req      = start_i && !stop_i;
  assign running        = (state_q != ST_IDLE);
  assign at_high_end    = (phase_q == (width_q - C_ONE));
  assign at_period_end  = (phase_q == (period_q - C_ONE));
  assign burst_complete = (burst_q != '0) && at_period_end && (pulse_cnt_q == burst_q);

  // State register together with every other registered value.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      period_q    <= '0;
      width_q     <= '0;
      burst_q     <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
      width_q     <= width_d;
      burst_q     <= burst_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req && cfg_valid) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (at_high_end) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (at_period_end) begin
          state_d = burst_complete ? ST_IDLE : ST_HIGH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    phase_d     = phase_q;
    period_d    = period_q;
    width_d     = width_q;
    burst_d     = burst_q;
    pulse_cnt_d = pulse_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          err_d = !cfg_valid;
          if (cfg_valid) begin
            period_d    = period_i;
            width_d     = width_i;
            burst_d     = burst_i;
            phase_d     = '0;
            pulse_cnt_d = B_ONE;
          end
        end
      end
      ST_HIGH, ST_LOW: begin
        if (stop_i) begin
          phase_d = '0;
          done_d  = 1'b1;
        end else if (at_period_end) begin
          phase_d = '0;
          if (burst_complete) begin
            done_d = 1'b1;
          end else begin
            // Only LOW can sit on the last phase, so this is a LOW->HIGH edge.
            // Continuous mode lets the counter wrap naturally.
            pulse_cnt_d = pulse_cnt_q + B_ONE;
          end
        end else begin
          phase_d = phase_q + C_ONE;
        end
      end
      default: begin
        phase_d = '0;
      end
    endcase

    // HIGH is exactly the span phase < width, so the pulse mirrors that state.
    pulse_d = (state_d == ST_HIGH);
  end

  assign pulse_o     = pulse_q & oe_i;
  assign busy_o      = running;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pulse_cnt_o = pulse_cnt_q;

endmodule

// File: tb/tb_cal_pulse_gen.sv
// tb/tb_cal_pulse_gen.sv - self-checking bench for cal_pulse_gen

module tb_cal_pulse_gen;

  localparam int CW = 32;
  localparam int BW = 16;
  localparam int CLK_PER = 8;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic [CW-1:0] period_i = '0;
  logic [CW-1:0] width_i = '0;
  logic [BW-1:0] burst_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          oe_i = 1'b1;
  logic          pulse_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [BW-1:0] pulse_cnt_o;

  cal_pulse_gen #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .period_i    (period_i),
    .width_i     (width_i),
    .burst_i     (burst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .oe_i        (oe_i),
    .pulse_o     (pulse_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  always #(CLK_PER/2) clk_i = ~clk_i;

  typedef struct {
    int          k;
    logic        pulse;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t    exp_q[$];
  int      n_pass = 0;
  int      n_total = 0;
  int      cur_p = 0;
  longint  last_rise = -1;
  logic    prev_pulse = 1'b0;
  logic [15:0] last_cnt = '0;

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic push_exp(int k, logic p, logic b, logic d, logic e, logic [15:0] c);
    exp_t x;
    x.k = k; x.pulse = p; x.busy = b; x.done = d; x.err = e; x.cnt = c;
    exp_q.push_back(x);
    last_cnt = c;
  endtask

  // Reference timeline of a run started at cycle 0 (sample after accepting edge).
  task automatic expect_run(int p, int w, int b, logic oe, int k0, int n);
    for (int k = k0; k < k0 + n; k++) begin
      logic active;
      logic [15:0] c;
      active = (b == 0) || (k < b * p);
      if (active) c = 16'((k / p) + 1);
      else        c = 16'(b);
      push_exp(k, active && ((k % p) < w) && oe, active,
               (b != 0) && (k == b * p), 1'b0, c);
    end
  endtask

  // Compare queued expectations, one per cycle, starting at the current sample point.
  task automatic drain();
    exp_t x;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_total++;
      if (pulse_o !== x.pulse) $display("FAIL pulse k=%0d got %b want %b", x.k, pulse_o, x.pulse);
      else n_pass++;
      n_total++;
      if (busy_o !== x.busy) $display("FAIL busy k=%0d got %b want %b", x.k, busy_o, x.busy);
      else n_pass++;
      n_total++;
      if (done_o !== x.done) $display("FAIL done k=%0d got %b want %b", x.k, done_o, x.done);
      else n_pass++;
      n_total++;
      if (err_o !== x.err) $display("FAIL err k=%0d got %b want %b", x.k, err_o, x.err);
      else n_pass++;
      n_total++;
      if (pulse_cnt_o !== x.cnt) $display("FAIL cnt k=%0d got %0d want %0d", x.k, pulse_cnt_o, x.cnt);
      else n_pass++;
      if (pulse_o === 1'b1 && prev_pulse === 1'b0) begin
        if (last_rise >= 0) begin
          n_total++;
          if (($time - last_rise) != longint'(cur_p * CLK_PER))
            $display("FAIL rise_spacing k=%0d got %0d want %0d", x.k, $time - last_rise, cur_p * CLK_PER);
          else n_pass++;
        end
        last_rise = $time;
      end
      prev_pulse = pulse_o;
      if (exp_q.size() > 0) step();
    end
  endtask

  task automatic do_start(int p, int w, int b);
    period_i = CW'(p);
    width_i  = CW'(w);
    burst_i  = BW'(b);
    start_i  = 1'b1;
    cur_p = p;
    last_rise = -1;
    prev_pulse = 1'b0;
    step();
    start_i  = 1'b0;
    // Latched config must not follow later input changes.
    period_i = CW'($urandom_range(1, 3));
    width_i  = CW'($urandom_range(0, 9));
    burst_i  = BW'($urandom_range(1, 9));
  endtask

  task automatic do_stop(logic [15:0] c);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    push_exp(-1, 1'b0, 1'b0, 1'b1, 1'b0, c);
    drain();
    step();
    push_exp(-2, 1'b0, 1'b0, 1'b0, 1'b0, c);
    drain();
  endtask

  task automatic test_reset();
    #1;
    push_exp(-10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drain();
    @(negedge clk_i);
    arst_i = 1'b0;
    step();
    push_exp(-11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drain();
  endtask

  task automatic test_continuous();
    do_start(20, 1, 0);
    expect_run(20, 1, 0, 1'b1, 0, 120);
    drain();
    // Start while busy is ignored and must not disturb the run.
    period_i = 32'd7; width_i = 32'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    expect_run(20, 1, 0, 1'b1, 120, 120);
    drain();
    do_stop(last_cnt);
  endtask

  task automatic test_burst();
    do_start(5, 2, 3);
    expect_run(5, 2, 3, 1'b1, 0, 17);
    drain();
  endtask

  task automatic test_invalid();
    logic [15:0] c;
    c = last_cnt;
    do_start(1, 1, 0);
    push_exp(-20, 1'b0, 1'b0, 1'b0, 1'b1, c);
    drain();
    do_start(4, 4, 0);
    push_exp(-21, 1'b0, 1'b0, 1'b0, 1'b1, c);
    drain();
    do_start(4, 0, 0);
    push_exp(-22, 1'b0, 1'b0, 1'b0, 1'b1, c);
    drain();
    do_start(4, 3, 2);
    expect_run(4, 3, 2, 1'b1, 0, 10);
    drain();
  endtask

  task automatic test_stop();
    do_start(10, 6, 0);
    expect_run(10, 6, 0, 1'b1, 0, 3);
    drain();
    do_stop(16'd1);
    // Stop alone and start+stop while idle do nothing.
    stop_i = 1'b1;
    step();
    push_exp(-30, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    drain();
    period_i = 32'd6; width_i = 32'd2; start_i = 1'b1;
    step();
    push_exp(-31, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    drain();
    start_i = 1'b0;
    stop_i = 1'b0;
    step();
  endtask

  task automatic test_oe_gated();
    oe_i = 1'b0;
    do_start(8, 3, 4);
    expect_run(8, 3, 4, 1'b0, 0, 34);
    drain();
    oe_i = 1'b1;
    // Combinational gating: raising oe mid-pulse shows up without a clock.
    do_start(8, 3, 1);
    oe_i = 1'b0;
    #1;
    n_total++;
    if (pulse_o !== 1'b0) $display("FAIL oe_low got %b want 0", pulse_o);
    else n_pass++;
    oe_i = 1'b1;
    #1;
    n_total++;
    if (pulse_o !== 1'b1) $display("FAIL oe_high got %b want 1", pulse_o);
    else n_pass++;
    expect_run(8, 3, 1, 1'b1, 0, 10);
    drain();
  endtask

  task automatic test_async_reset();
    do_start(8, 4, 3);
    expect_run(8, 4, 3, 1'b1, 0, 3);
    drain();
    #1;
    arst_i = 1'b1;
    #1;
    prev_pulse = 1'b0;
    push_exp(-40, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drain();
    #1;
    arst_i = 1'b0;
    step();
    step();
    push_exp(-41, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drain();
    do_start(6, 3, 0);
    expect_run(6, 3, 0, 1'b1, 0, 14);
    drain();
    do_stop(last_cnt);
  endtask

  task automatic test_back_to_back();
    do_start(3, 1, 2);
    expect_run(3, 1, 2, 1'b1, 0, 7);
    drain();
    do_start(4, 2, 2);
    expect_run(4, 2, 2, 1'b1, 0, 10);
    drain();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_invalid();
    test_stop();
    test_oe_gated();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
